// File: rtl/ram_sync_clr.sv
// Single-port-write / single-port-read synchronous RAM with a sequential clear engine.
// After reset or a clr pulse, every word is zeroed one per cycle before accesses resume.
module ram_sync_clr #(
  parameter int unsigned AW = 4,
  parameter int unsigned DW = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-1:0] wadr,
  input  logic [DW-1:0] din,
  input  logic          re,
  input  logic [AW-1:0] radr,
  output logic [DW-1:0] dout,
  output logic          dvalid,
  output logic          busy
);

  localparam int unsigned DEPTH = 2**AW;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_e;

  state_e        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] dout_q, dout_d;
  logic          dvalid_q, dvalid_d;

  logic [DW-1:0] mem [DEPTH];
  logic          mem_we;
  logic [AW-1:0] mem_wa;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] rd_data;

  // Write-first bypass when reading the word being written this cycle
  assign rd_data = (we && (wadr == radr)) ? din : mem[radr];

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dout_d   = dout_q;
    dvalid_d = 1'b0;
    mem_we   = 1'b0;
    mem_wa   = wadr;
    mem_wd   = din;
    unique case (state_q)
      CLEAR: begin
        mem_we = 1'b1;
        mem_wa = cnt_q;
        mem_wd = '0;
        if (clr) begin
          cnt_d = '0;
        end else if (cnt_q == AW'(DEPTH - 1)) begin
          state_d = READY;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + AW'(1);
        end
      end
      READY: begin
        if (clr) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end else begin
          mem_we   = we;
          dvalid_d = re;
          if (re) begin
            dout_d = rd_data;
          end
        end
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= CLEAR;
      cnt_q    <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dout_q   <= dout_d;
      dvalid_q <= dvalid_d;
    end
  end

  // Storage array: no reset, zeroed only through the CLEAR walk
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_wa] <= mem_wd;
    end
  end

  assign dout   = dout_q;
  assign dvalid = dvalid_q;
  assign busy   = (state_q == CLEAR);

endmodule

// File: tb/tb_ram_sync_clr.sv
// Scoreboard bench for ram_sync_clr: directed scenarios plus random traffic
// checked against an array-based reference model.
module tb_ram_sync_clr;

  localparam int unsigned AW    = 4;
  localparam int unsigned DW    = 4;
  localparam int unsigned DEPTH = 2**AW;

  logic          clk   = 1'b0;
  logic          rst_n = 1'b0;
  logic          clr   = 1'b0;
  logic          we    = 1'b0;
  logic          re    = 1'b0;
  logic [AW-1:0] wadr  = '0;
  logic [AW-1:0] radr  = '0;
  logic [DW-1:0] din   = '0;
  logic [DW-1:0] dout;
  logic          dvalid;
  logic          busy;

  typedef struct packed {
    logic          v;
    logic [DW-1:0] d;
  } exp_t;

  exp_t          q[$];
  exp_t          m_e;
  int            tests = 0;
  int            fails = 0;
  int            busy_left;
  logic [DW-1:0] ref_mem [DEPTH];
  logic [DW-1:0] ref_dout;

  ram_sync_clr #(.AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (clr),
    .we    (we),
    .wadr  (wadr),
    .din   (din),
    .re    (re),
    .radr  (radr),
    .dout  (dout),
    .dvalid(dvalid),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // A clear leaves every word zero; accesses during it have no effect
  function automatic void start_clear();
    foreach (ref_mem[i]) ref_mem[i] = '0;
    busy_left = DEPTH;
  endfunction

  // One clock cycle of stimulus, entered and left at a falling edge
  task automatic cyc(input logic c, input logic w, input logic [AW-1:0] wa,
                     input logic [DW-1:0] d, input logic r, input logic [AW-1:0] ra);
    exp_t e;
    check("busy", 32'(busy), 32'(busy_left > 0));
    clr = c; we = w; wadr = wa; din = d; re = r; radr = ra;
    e.v = 1'b0;
    if (c) begin
      start_clear();
    end else if (busy_left > 0) begin
      busy_left--;
    end else begin
      if (r) begin
        ref_dout = (w && wa == ra) ? d : ref_mem[ra];
        e.v      = 1'b1;
      end
      if (w) ref_mem[wa] = d;
    end
    e.d = ref_dout;
    q.push_back(e);
    @(negedge clk);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, '0, '0, 1'b0, '0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    clr = 1'b0; we = 1'b0; re = 1'b0;
    q.delete();
    #1;
    check("rst_dout",   32'(dout),   32'd0);
    check("rst_dvalid", 32'(dvalid), 32'd0);
    check("rst_busy",   32'(busy),   32'd1);
    start_clear();
    ref_dout = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic read_all();
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, 1'b0, '0, '0, 1'b1, AW'(i));
  endtask

  // Monitor: pops one expectation per active edge that followed a stimulus cycle
  always @(posedge clk) begin
    #1;
    if (q.size() > 0) begin
      m_e = q.pop_front();
      check("dvalid", 32'(dvalid), 32'(m_e.v));
      check("dout",   32'(dout),   32'(m_e.d));
    end
  end

  initial begin
    @(negedge clk);
    do_reset();

    // Power-up clear then every word reads zero
    repeat (DEPTH) idle();
    read_all();

    // Write then read back
    cyc(1'b0, 1'b1, AW'(3), DW'(4'hA), 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, AW'(3));

    // Write-first collision
    cyc(1'b0, 1'b1, AW'(5), DW'(4'h2), 1'b0, '0);
    cyc(1'b0, 1'b1, AW'(5), DW'(4'h9), 1'b1, AW'(5));
    cyc(1'b0, 1'b0, '0, '0, 1'b1, AW'(5));

    // Streaming reads after mem[i]=i
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, 1'b1, AW'(i), DW'(i), 1'b0, '0);
    read_all();

    // clr with traffic during busy
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, 1'b1, AW'(i), DW'(15 - i), 1'b0, '0);
    cyc(1'b1, 1'b1, AW'(2), DW'(7), 1'b1, AW'(2));
    for (int i = 0; i < int'(DEPTH); i++)
      cyc(1'b0, 1'b1, AW'($urandom), DW'($urandom), 1'b1, AW'($urandom));
    read_all();

    // Reset in the middle of a clear, with dout holding a non-zero word
    for (int i = 0; i < int'(DEPTH); i++) cyc(1'b0, 1'b1, AW'(i), DW'(i + 1), 1'b0, '0);
    cyc(1'b0, 1'b0, '0, '0, 1'b1, AW'(5));
    cyc(1'b1, 1'b0, '0, '0, 1'b0, '0);
    repeat (7) idle();
    do_reset();
    repeat (DEPTH) idle();
    read_all();

    // Random traffic with occasional clr, including restarts mid-clear
    repeat (800) begin
      cyc(1'($urandom_range(0, 59) == 0), 1'($urandom_range(0, 1)), AW'($urandom),
          DW'($urandom), 1'($urandom_range(0, 1)), AW'($urandom));
    end
    repeat (DEPTH + 1) idle();
    read_all();

    check("queue_drained", 32'(q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
